// File: rtl/txpacketbuild.sv
// Reply serializer: emits the EPC Gen2-style reply selected by a one-hot command, one bit
// per bitinclk edge, with serial memory fetch and a trailing CRC-16 where the reply needs it.
module txpacketbuild (
    input  logic        bitinclk,
    input  logic        reset,
    input  logic        txenable,
    input  logic [11:0] txtype,
    input  logic [15:0] currentrn,
    input  logic [15:0] currenthandle,
    input  logic [15:0] pcword,
    input  logic [7:0]  readwords,
    input  logic [15:0] sensdata,
    input  logic        memdatain,
    output logic        memdataclk,
    output logic        txbit,
    output logic        txdone
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_PC,
        ST_MEM,
        ST_RN,
        ST_SENS,
        ST_HANDLE,
        ST_CRC,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  wordcnt_q, wordcnt_d;
    logic [15:0] crc_q, crc_d;
    logic [11:0] type_q, type_d;
    logic [7:0]  memwords_q, memwords_d;
    logic        txbit_q, txbit_d;
    logic        txdone_q, txdone_d;
    logic        memdataen_q, memdataen_d;
    logic        memdataengated_q;

    // Type decode: at the start edge the live txtype is used, afterwards the latched copy.
    logic [11:0] typ;
    logic        onehot;
    logic        is_query, is_reqrn, is_ack, is_read, is_write, is_sens;
    state_t      first_field;
    logic [7:0]  start_words;

    always_comb begin
        typ      = (state_q == ST_IDLE) ? txtype : type_q;
        onehot   = (typ != 12'd0) && ((typ & (typ - 12'd1)) == 12'd0);
        is_query = onehot & (typ[0] | typ[2] | typ[3]);
        is_reqrn = onehot & typ[6];
        is_ack   = onehot & typ[1];
        is_read  = onehot & typ[7];
        is_write = onehot & typ[8];
        is_sens  = onehot & typ[11];

        if (is_query || is_reqrn) begin
            first_field = ST_RN;
        end else if (is_ack) begin
            first_field = ST_PC;
        end else if (is_read || is_write || is_sens) begin
            first_field = ST_HDR;
        end else begin
            first_field = ST_DONE;
        end

        if (is_ack) begin
            start_words = {3'b000, pcword[15:11]};
        end else if (is_read) begin
            start_words = readwords;
        end else begin
            start_words = 8'd0;
        end
    end

    // field is the field whose bit goes out on this edge; cur_* are its counters.
    state_t      field;
    logic [3:0]  cur_bitcnt;
    logic [3:0]  bitsel;
    logic [7:0]  cur_wordcnt;
    logic [7:0]  cur_words;
    logic [15:0] cur_crc;
    logic [15:0] crc_step;
    logic        fbit;
    logic        fb;
    logic        last_bit;

    always_comb begin
        field       = state_q;
        cur_bitcnt  = bitcnt_q;
        cur_wordcnt = wordcnt_q;
        cur_words   = memwords_q;
        cur_crc     = crc_q;
        if (state_q == ST_IDLE) begin
            field       = first_field;
            cur_bitcnt  = 4'd0;
            cur_wordcnt = 8'd0;
            cur_words   = start_words;
            cur_crc     = 16'hFFFF;
        end
        bitsel = ~cur_bitcnt;

        case (field)
            ST_PC:     fbit = pcword[bitsel];
            ST_MEM:    fbit = memdatain;
            ST_RN:     fbit = currentrn[bitsel];
            ST_SENS:   fbit = sensdata[bitsel];
            ST_HANDLE: fbit = currenthandle[bitsel];
            ST_CRC:    fbit = ~cur_crc[15];
            default:   fbit = 1'b0;
        endcase

        fb       = cur_crc[15] ^ fbit;
        crc_step = {cur_crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        last_bit = (field == ST_HDR) || (cur_bitcnt == 4'hF);
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        wordcnt_d   = wordcnt_q;
        crc_d       = crc_q;
        type_d      = type_q;
        memwords_d  = memwords_q;
        txbit_d     = txbit_q;
        txdone_d    = txdone_q;
        memdataen_d = memdataen_q;

        if (!txenable) begin
            // Abort or re-arm: everything returns to the idle picture.
            state_d     = ST_IDLE;
            bitcnt_d    = 4'd0;
            wordcnt_d   = 8'd0;
            crc_d       = 16'hFFFF;
            txbit_d     = 1'b0;
            txdone_d    = 1'b0;
            memdataen_d = 1'b0;
        end else if (field == ST_DONE) begin
            // Covers both a finished reply and a type with no reply at all.
            state_d     = ST_DONE;
            type_d      = typ;
            txbit_d     = 1'b0;
            txdone_d    = 1'b1;
            memdataen_d = 1'b0;
        end else begin
            type_d     = typ;
            memwords_d = cur_words;
            txbit_d    = fbit;
            txdone_d   = 1'b0;
            crc_d      = (field == ST_CRC) ? {cur_crc[14:0], 1'b0} : crc_step;
            bitcnt_d   = last_bit ? 4'd0 : cur_bitcnt + 4'd1;
            wordcnt_d  = cur_wordcnt;
            state_d    = field;

            if (last_bit) begin
                case (field)
                    ST_HDR: begin
                        if (is_read) begin
                            state_d = (cur_words == 8'd0) ? ST_HANDLE : ST_MEM;
                        end else if (is_write) begin
                            state_d = ST_HANDLE;
                        end else begin
                            state_d = ST_SENS;
                        end
                    end
                    ST_PC:     state_d = (cur_words == 8'd0) ? ST_CRC : ST_MEM;
                    ST_MEM: begin
                        if (cur_wordcnt + 8'd1 == cur_words) begin
                            wordcnt_d = 8'd0;
                            state_d   = is_ack ? ST_CRC : ST_HANDLE;
                        end else begin
                            wordcnt_d = cur_wordcnt + 8'd1;
                            state_d   = ST_MEM;
                        end
                    end
                    ST_RN:     state_d = is_reqrn ? ST_CRC : ST_DONE;
                    ST_SENS:   state_d = ST_HANDLE;
                    ST_HANDLE: state_d = ST_CRC;
                    default:   state_d = ST_DONE;
                endcase
            end

            // Enable runs one edge ahead of the edges that consume memory bits.
            memdataen_d = (state_d == ST_MEM);
        end
    end

    always_ff @(posedge bitinclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 4'd0;
            wordcnt_q   <= 8'd0;
            crc_q       <= 16'hFFFF;
            type_q      <= 12'd0;
            memwords_q  <= 8'd0;
            txbit_q     <= 1'b0;
            txdone_q    <= 1'b0;
            memdataen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            wordcnt_q   <= wordcnt_d;
            crc_q       <= crc_d;
            type_q      <= type_d;
            memwords_q  <= memwords_d;
            txbit_q     <= txbit_d;
            txdone_q    <= txdone_d;
            memdataen_q <= memdataen_d;
        end
    end

    // Gate updates while bitinclk is low, so the AND below cannot glitch.
    always_ff @(negedge bitinclk or posedge reset) begin
        if (reset) begin
            memdataengated_q <= 1'b0;
        end else begin
            memdataengated_q <= memdataen_q;
        end
    end

    assign memdataclk = bitinclk & memdataengated_q;
    assign txbit      = txbit_q;
    assign txdone     = txdone_q;

endmodule

// File: tb/tb_txpacketbuild.sv
// Bench for txpacketbuild: a packet-level reference model checked every cycle, directed
// literal cases, and randomized replies with random aborts.
module tb_txpacketbuild;

    logic        bitinclk = 1'b0;
    logic        reset = 1'b1;
    logic        txenable = 1'b0;
    logic [11:0] txtype = 12'd0;
    logic [15:0] currentrn = 16'd0;
    logic [15:0] currenthandle = 16'd0;
    logic [15:0] pcword = 16'd0;
    logic [7:0]  readwords = 8'd0;
    logic [15:0] sensdata = 16'd0;
    logic        memdatain;
    logic        memdataclk;
    logic        txbit;
    logic        txdone;

    txpacketbuild dut (
        .bitinclk      (bitinclk),
        .reset         (reset),
        .txenable      (txenable),
        .txtype        (txtype),
        .currentrn     (currentrn),
        .currenthandle (currenthandle),
        .pcword        (pcword),
        .readwords     (readwords),
        .sensdata      (sensdata),
        .memdatain     (memdatain),
        .memdataclk    (memdataclk),
        .txbit         (txbit),
        .txdone        (txdone)
    );

    always #5 bitinclk = ~bitinclk;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Serial memory: advances one bit after every memdataclk rising edge.
    logic [15:0] mem_arr [0:255];
    int          ptr = 0;
    int          ptr_base = 0;
    logic [31:0] moff;
    logic [15:0] mem_word;
    always @(posedge memdataclk) ptr <= ptr + 1;
    assign moff      = 32'(ptr - ptr_base);
    assign mem_word  = mem_arr[moff[11:4]];
    assign memdatain = mem_word[~moff[3:0]];

    // Reference model: the whole reply is built as a bit list at the start edge.
    bit   mdl_bits[$];
    int   mdl_pos = 0;
    int   mdl_mode = 0;
    logic exp_txbit = 1'b0;
    logic exp_txdone = 1'b0;

    function automatic void push16(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) mdl_bits.push_back(v[i]);
    endfunction

    function automatic void push_crc();
        logic [15:0] c;
        logic        f;
        c = 16'hFFFF;
        foreach (mdl_bits[i]) begin
            f = c[15] ^ mdl_bits[i];
            c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
        end
        c = ~c;
        push16(c);
    endfunction

    function automatic void build_packet();
        logic [11:0] t;
        t = txtype;
        mdl_bits.delete();
        if (t == 12'd0 || (t & (t - 12'd1)) != 12'd0) return;
        if (t[0] | t[2] | t[3]) begin
            push16(currentrn);
        end else if (t[6]) begin
            push16(currentrn);
            push_crc();
        end else if (t[1]) begin
            push16(pcword);
            for (int w = 0; w < int'(pcword[15:11]); w++) push16(mem_arr[w]);
            push_crc();
        end else if (t[7]) begin
            mdl_bits.push_back(1'b0);
            for (int w = 0; w < int'(readwords); w++) push16(mem_arr[w]);
            push16(currenthandle);
            push_crc();
        end else if (t[8]) begin
            mdl_bits.push_back(1'b0);
            push16(currenthandle);
            push_crc();
        end else if (t[11]) begin
            mdl_bits.push_back(1'b0);
            push16(sensdata);
            push16(currenthandle);
            push_crc();
        end
    endfunction

    always @(posedge bitinclk or posedge reset) begin
        if (reset || !txenable) begin
            mdl_mode   <= 0;
            exp_txbit  <= 1'b0;
            exp_txdone <= 1'b0;
        end else if (mdl_mode == 0) begin
            build_packet();
            if (mdl_bits.size() == 0) begin
                exp_txbit  <= 1'b0;
                exp_txdone <= 1'b1;
                mdl_mode   <= 2;
            end else begin
                exp_txbit <= mdl_bits[0];
                mdl_pos   <= 1;
                mdl_mode  <= 1;
            end
        end else if (mdl_mode == 1) begin
            if (mdl_pos < mdl_bits.size()) begin
                exp_txbit <= mdl_bits[mdl_pos];
                mdl_pos   <= mdl_pos + 1;
            end else begin
                exp_txbit  <= 1'b0;
                exp_txdone <= 1'b1;
                mdl_mode   <= 2;
            end
        end
    end

    always @(negedge bitinclk) begin
        if (cmp_en && !reset) begin
            chk("cycle txbit", txbit, exp_txbit);
            chk("cycle txdone", txdone, exp_txdone);
        end
    end

    // Captured DUT bits of the current reply.
    bit cap[$];
    int done_edge;

    function automatic logic [15:0] pack16(input int off);
        logic [15:0] r;
        r = 16'd0;
        for (int i = 0; i < 16; i++)
            r = {r[14:0], (off + i < cap.size()) ? cap[off + i] : 1'b0};
        return r;
    endfunction

    function automatic logic [15:0] residue();
        logic [15:0] c;
        logic        f;
        c = 16'hFFFF;
        foreach (cap[i]) begin
            f = c[15] ^ cap[i];
            c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic run_pkt(input logic [11:0] t, input int abort_at, input int exp_len,
                           input int exp_pulses, input bit crc_on, input bit from_reset,
                           input string nm);
        int p;
        if (!from_reset) begin
            @(negedge bitinclk);
            txtype   = t;
            ptr_base = ptr;
            txenable = 1'b1;
        end
        cap.delete();
        done_edge = -1;
        for (int e = 0; e < 1200; e++) begin
            @(posedge bitinclk);
            #1;
            if (txdone) begin
                done_edge = e;
                break;
            end
            cap.push_back(txbit);
            if (e == abort_at) break;
        end
        if (abort_at >= 0 && done_edge < 0) begin
            @(negedge bitinclk);
            txenable = 1'b0;
            @(posedge bitinclk);
            #1;
            chk({nm, " abort txbit"}, txbit, 0);
            chk({nm, " abort txdone"}, txdone, 0);
            p = ptr;
            repeat (3) @(posedge bitinclk);
            #1;
            chk({nm, " abort memclk quiet"}, ptr, p);
        end else begin
            chk({nm, " done edge"}, done_edge, exp_len);
            chk({nm, " txbit at done"}, txbit, 0);
            chk({nm, " memclk pulses"}, ptr - ptr_base, exp_pulses);
            if (crc_on) chk({nm, " crc residue"}, residue(), 16'h1D0F);
            @(negedge bitinclk);
            txenable = 1'b0;
            @(posedge bitinclk);
            #1;
            chk({nm, " txdone cleared"}, txdone, 0);
        end
        $display("pkt %s type=%03h len=%0d done_edge=%0d pulses=%0d", nm, t, cap.size(),
                 done_edge, ptr - ptr_base);
    endtask

    function automatic int len_of(input logic [11:0] t);
        if (t == 12'd0 || (t & (t - 12'd1)) != 12'd0) return 0;
        if (t[0] | t[2] | t[3]) return 16;
        if (t[6]) return 32;
        if (t[1]) return 32 + 16 * int'(pcword[15:11]);
        if (t[7]) return 33 + 16 * int'(readwords);
        if (t[8]) return 33;
        if (t[11]) return 49;
        return 0;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] t;
        int          r;
        int          len;
        int          pulses;
        int          ab;

        for (int i = 0; i < 256; i++) mem_arr[i] = 16'(i * 16'h0101);

        repeat (3) @(posedge bitinclk);
        #1;
        chk("reset txbit", txbit, 0);
        chk("reset txdone", txdone, 0);
        chk("reset memdataclk", memdataclk, 0);
        @(negedge bitinclk);
        #2;
        reset  = 1'b0;
        cmp_en = 1'b1;

        currentrn = 16'hA5C3;
        run_pkt(12'h004, -1, 16, 0, 1'b0, 1'b0, "query");
        chk("query bits", pack16(0), 16'hA5C3);

        currentrn = 16'h1234;
        run_pkt(12'h040, -1, 32, 0, 1'b1, 1'b0, "reqrn");
        chk("reqrn rn bits", pack16(0), 16'h1234);

        readwords     = 8'd2;
        mem_arr[0]    = 16'hBEEF;
        mem_arr[1]    = 16'h0001;
        currenthandle = 16'h5555;
        run_pkt(12'h080, -1, 65, 32, 1'b1, 1'b0, "read");
        chk("read header bit", 32'(cap[0]), 0);
        chk("read word0", pack16(1), 16'hBEEF);
        chk("read word1", pack16(17), 16'h0001);
        chk("read handle", pack16(33), 16'h5555);

        pcword = 16'h3000;
        run_pkt(12'h002, -1, 128, 96, 1'b1, 1'b0, "ack_e6");
        chk("ack pc bits", pack16(0), 16'h3000);
        pcword = 16'h0000;
        run_pkt(12'h002, -1, 32, 0, 1'b1, 1'b0, "ack_e0");

        run_pkt(12'h400, -1, 0, 0, 1'b0, 1'b0, "sampsens");

        currenthandle = 16'h9A3C;
        run_pkt(12'h100, -1, 33, 0, 1'b1, 1'b0, "write");
        sensdata = 16'hC0DE;
        run_pkt(12'h800, -1, 49, 0, 1'b1, 1'b0, "sensdata");
        chk("sens word", pack16(1), 16'hC0DE);

        readwords = 8'd4;
        run_pkt(12'h080, 20, 0, 0, 1'b0, 1'b0, "read_abort");

        // Asynchronous reset in the middle of an ACK, while bitinclk is high.
        pcword = 16'h3000;
        @(negedge bitinclk);
        txtype   = 12'h002;
        ptr_base = ptr;
        txenable = 1'b1;
        repeat (20) @(posedge bitinclk);
        #1;
        chk("ack mem clk high", memdataclk, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("async rst txbit", txbit, 0);
        chk("async rst txdone", txdone, 0);
        chk("async rst memdataclk", memdataclk, 0);
        currentrn = 16'h0F0F;
        txtype    = 12'h001;
        @(negedge bitinclk);
        ptr_base = ptr;
        #2;
        reset = 1'b0;
        run_pkt(12'h001, -1, 16, 0, 1'b0, 1'b1, "start_after_reset");
        chk("post reset rn", pack16(0), 16'h0F0F);

        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 13);
            if (r < 12) t = 12'(1 << r);
            else if (r == 12) t = 12'h000;
            else t = 12'h081;
            currentrn     = 16'($urandom);
            currenthandle = 16'($urandom);
            sensdata      = 16'($urandom);
            pcword        = {5'($urandom_range(0, 4)), 11'($urandom)};
            readwords     = 8'($urandom_range(0, 4));
            for (int w = 0; w < 5; w++) mem_arr[w] = 16'($urandom);
            len    = len_of(t);
            pulses = 0;
            if (len > 0 && t == 12'h002) pulses = 16 * int'(pcword[15:11]);
            if (len > 0 && t == 12'h080) pulses = 16 * int'(readwords);
            ab = -1;
            if (len > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, len - 1);
            run_pkt(t, ab, len, pulses, (len > 16), 1'b0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
